// File: rtl/nmea_zda_tx_if.sv
// nmea_zda_tx_if: byte stream with valid/ready handshake.
// master drives the data and valid signals; slave drives ready.
interface nmea_zda_tx_if #(
  parameter int unsigned B = 8
);
  logic [B-1:0] out_data;
  logic         out_valid;
  logic         out_ready;

  modport master (output out_data, output out_valid, input out_ready);
  modport slave  (input out_data, input out_valid, output out_ready);
endinterface

// File: rtl/nmea_zda_tx.sv
// nmea_zda_tx: serializes one NMEA ZDA sentence from BCD time/date fields
// onto a valid/ready byte stream.
// Define NMEA_ZDA_TX_CHECKSUM_EN to append the "*HH" XOR checksum
// (38 bytes). Without it the sentence ends "00\r\n" (35 bytes).
module nmea_zda_tx #(
  parameter int unsigned B      = 8,
  parameter logic [15:0] TALKER = "GP"
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          restart,
  input  logic          start,
  input  logic [7:0]    hour,
  input  logic [7:0]    minute,
  input  logic [7:0]    second,
  input  logic [7:0]    centi,
  input  logic [7:0]    day,
  input  logic [7:0]    month,
  input  logic [15:0]   year,
  nmea_zda_tx_if.master tx,
  output logic          busy,
  output logic          done
);

  typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

`ifdef NMEA_ZDA_TX_CHECKSUM_EN
  localparam logic [5:0] LAST = 6'd37;
`else
  localparam logic [5:0] LAST = 6'd34;
`endif

  state_t      state, state_next;
  logic [5:0]  idx, idx_next;
  logic [7:0]  data_q, data_next;
  logic        load, xfer;
  logic [7:0]  hour_q, minute_q, second_q, centi_q, day_q, month_q;
  logic [15:0] year_q;
`ifdef NMEA_ZDA_TX_CHECKSUM_EN
  logic [7:0]  cks, cks_next;

  function automatic logic [7:0] hexc(input logic [3:0] n);
    return (n > 4'd9) ? 8'h37 + {4'h0, n} : 8'h30 + {4'h0, n};
  endfunction
`endif

  function automatic logic [7:0] dig(input logic [3:0] n);
    return 8'h30 + {4'h0, n};
  endfunction

  assign xfer         = tx.out_valid && tx.out_ready;
  assign tx.out_valid = (state == SEND);
  assign tx.out_data  = B'(data_q);
  assign busy         = (state == SEND);
  assign done         = (state == DONE);

  // Next state, byte index and running checksum; restart overrides everything.
  always_comb begin
    state_next = state;
    idx_next   = idx;
    load       = 1'b0;
`ifdef NMEA_ZDA_TX_CHECKSUM_EN
    cks_next   = cks;
`endif
    if (restart) begin
      state_next = IDLE;
      idx_next   = '0;
`ifdef NMEA_ZDA_TX_CHECKSUM_EN
      cks_next   = '0;
`endif
    end else begin
      case (state)
        IDLE: if (start) begin
          state_next = SEND;
          idx_next   = '0;
          load       = 1'b1;
`ifdef NMEA_ZDA_TX_CHECKSUM_EN
          cks_next   = '0;
`endif
        end
        SEND: if (xfer) begin
`ifdef NMEA_ZDA_TX_CHECKSUM_EN
          // Covers the talker ID through the byte just before '*'.
          if (idx != 6'd0 && idx < 6'd33) cks_next = cks ^ data_q;
`endif
          if (idx == LAST) begin
            state_next = DONE;
            idx_next   = '0;
          end else begin
            idx_next = idx + 6'd1;
          end
        end
        DONE:    state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  // Character presented for the index the sentence moves to; looking at the
  // next index keeps out_data registered with no path from out_ready.
  always_comb begin
    data_next = 8'h00;
    if (state_next == SEND) begin
      case (idx_next)
        6'd0:  data_next = "$";
        6'd1:  data_next = TALKER[15:8];
        6'd2:  data_next = TALKER[7:0];
        6'd3:  data_next = "Z";
        6'd4:  data_next = "D";
        6'd5:  data_next = "A";
        6'd6, 6'd16, 6'd19, 6'd22, 6'd27, 6'd30: data_next = ",";
        6'd7:  data_next = dig(hour_q[7:4]);
        6'd8:  data_next = dig(hour_q[3:0]);
        6'd9:  data_next = dig(minute_q[7:4]);
        6'd10: data_next = dig(minute_q[3:0]);
        6'd11: data_next = dig(second_q[7:4]);
        6'd12: data_next = dig(second_q[3:0]);
        6'd13: data_next = ".";
        6'd14: data_next = dig(centi_q[7:4]);
        6'd15: data_next = dig(centi_q[3:0]);
        6'd17: data_next = dig(day_q[7:4]);
        6'd18: data_next = dig(day_q[3:0]);
        6'd20: data_next = dig(month_q[7:4]);
        6'd21: data_next = dig(month_q[3:0]);
        6'd23: data_next = dig(year_q[15:12]);
        6'd24: data_next = dig(year_q[11:8]);
        6'd25: data_next = dig(year_q[7:4]);
        6'd26: data_next = dig(year_q[3:0]);
        6'd28, 6'd29, 6'd31, 6'd32: data_next = "0";
`ifdef NMEA_ZDA_TX_CHECKSUM_EN
        6'd33: data_next = "*";
        6'd34: data_next = hexc(cks_next[7:4]);
        6'd35: data_next = hexc(cks_next[3:0]);
        6'd36: data_next = 8'h0D;
        6'd37: data_next = 8'h0A;
`else
        6'd33: data_next = 8'h0D;
        6'd34: data_next = 8'h0A;
`endif
        default: data_next = 8'h00;
      endcase
    end
  end

  // State, index, output byte and checksum registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      idx    <= '0;
      data_q <= '0;
`ifdef NMEA_ZDA_TX_CHECKSUM_EN
      cks    <= '0;
`endif
    end else begin
      state  <= state_next;
      idx    <= idx_next;
      data_q <= data_next;
`ifdef NMEA_ZDA_TX_CHECKSUM_EN
      cks    <= cks_next;
`endif
    end
  end

  // Shadow copies of the fields, captured only when a sentence is accepted.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      hour_q   <= '0;
      minute_q <= '0;
      second_q <= '0;
      centi_q  <= '0;
      day_q    <= '0;
      month_q  <= '0;
      year_q   <= '0;
    end else if (load) begin
      hour_q   <= hour;
      minute_q <= minute;
      second_q <= second;
      centi_q  <= centi;
      day_q    <= day;
      month_q  <= month;
      year_q   <= year;
    end
  end

endmodule

// File: tb/tb_nmea_zda_tx.sv
// tb_nmea_zda_tx: table vectors plus randomized sentences for nmea_zda_tx.
// Expected bytes come from hand-written sentence strings or from a
// string-formatting reference model of the ZDA sentence.
module tb_nmea_zda_tx;

  typedef logic [7:0] bq_t[$];
  typedef struct {
    logic [7:0]  hour, minute, second, centi, day, month;
    logic [15:0] year;
  } fields_t;
  typedef struct {
    fields_t f;
    string   body;
    string   cks;
  } vec_t;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        restart = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  hour = '0, minute = '0, second = '0, centi = '0, day = '0, month = '0;
  logic [15:0] year = '0;
  logic        busy, done;
  int          n_chk = 0;
  int          n_fail = 0;

  nmea_zda_tx_if #(.B(8)) tx_if();

  nmea_zda_tx #(.B(8), .TALKER("GP")) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .restart (restart),
    .start   (start),
    .hour    (hour),
    .minute  (minute),
    .second  (second),
    .centi   (centi),
    .day     (day),
    .month   (month),
    .year    (year),
    .tx      (tx_if),
    .busy    (busy),
    .done    (done)
  );

  always #5 clock = ~clock;

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish, required finish");
    $fatal(1);
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", nm, act, req);
    end
  endtask

  function automatic fields_t mkf(input logic [7:0] h, m, s, c, d, mo, input logic [15:0] y);
    fields_t f;
    f.hour = h; f.minute = m; f.second = s; f.centi = c;
    f.day = d; f.month = mo; f.year = y;
    return f;
  endfunction

  function automatic logic [7:0] rbyte(input bit wild);
    if (wild) return 8'($urandom_range(0, 255));
    return {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
  endfunction

  function automatic fields_t rnd_fields(input bit wild);
    return mkf(rbyte(wild), rbyte(wild), rbyte(wild), rbyte(wild),
               rbyte(wild), rbyte(wild), {rbyte(wild), rbyte(wild)});
  endfunction

  task automatic set_fields(input fields_t f);
    hour = f.hour; minute = f.minute; second = f.second; centi = f.centi;
    day = f.day; month = f.month; year = f.year;
  endtask

  function automatic bq_t str_bytes(input string s);
    bq_t q;
    for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
    return q;
  endfunction

  function automatic bq_t vec_expect(input vec_t v);
`ifdef NMEA_ZDA_TX_CHECKSUM_EN
    return str_bytes({"$", v.body, "*", v.cks, "\r\n"});
`else
    return str_bytes({"$", v.body, "\r\n"});
`endif
  endfunction

  // Reference model: format the fields as hex text, then remap nibbles
  // above 9 to 0x30+nibble, XOR the body, append the uppercase checksum.
  function automatic bq_t model(input fields_t f);
    string      body;
    bq_t        q;
    logic [7:0] c, ck;
    body = $sformatf("GPZDA,%02h%02h%02h.%02h,%02h,%02h,%04h,00,00",
                     f.hour, f.minute, f.second, f.centi, f.day, f.month, f.year);
    ck = 8'h00;
    q.push_back("$");
    for (int i = 0; i < body.len(); i++) begin
      c = body[i];
      if (c >= "a" && c <= "f") c = c - "a" + 8'h3A;
      ck ^= c;
      q.push_back(c);
    end
`ifdef NMEA_ZDA_TX_CHECKSUM_EN
    body = $sformatf("*%02X", ck);
    for (int i = 0; i < body.len(); i++) q.push_back(body[i]);
`endif
    q.push_back(8'h0D);
    q.push_back(8'h0A);
    return q;
  endfunction

  // mode 0: ready held high; 1: random ready; 2: random ready plus field
  // changes and start pulses while the sentence is in flight.
  task automatic run_one(input string name, input fields_t f, input bq_t exp,
                         input int mode, input bit start_in_done);
    bq_t        got;
    int         cyc;
    bit         seen, stall;
    logic [7:0] held;
    cyc = 0; seen = 1'b0; stall = 1'b0; held = 8'h00;
    set_fields(f);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    while (!seen && cyc < 4000) begin
      if (done) begin
        seen = 1'b1;
        check({name, " done_len"}, 64'(got.size()), 64'(exp.size()));
        check({name, " done_busy_valid"}, {busy, tx_if.out_valid}, 2'b00);
        if (mode == 0) check({name, " done_cycles"}, 64'(cyc), 64'(exp.size()));
        start = start_in_done;
      end else begin
        if (stall) check({name, " stable"}, {tx_if.out_valid, tx_if.out_data}, {1'b1, held});
        check({name, " busy"}, {busy, tx_if.out_valid}, 2'b11);
        tx_if.out_ready = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
        if (mode == 2) begin
          if (cyc == 0) hour = 8'h23;
          if (cyc == 3 || cyc == 9 || cyc == 20) begin
            set_fields(rnd_fields(1'b0));
            start = 1'b1;
          end else begin
            start = 1'b0;
          end
        end
        if (tx_if.out_valid && tx_if.out_ready) got.push_back(tx_if.out_data);
        stall = tx_if.out_valid && !tx_if.out_ready;
        held  = tx_if.out_data;
      end
      @(negedge clock);
      cyc++;
    end
    check({name, " done_seen"}, 64'(seen), 64'd1);
    for (int i = 0; i < exp.size() && i < got.size(); i++)
      check($sformatf("%s byte %0d", name, i), got[i], exp[i]);
    if (start_in_done) begin
      check({name, " start_in_done_ignored"}, {busy, tx_if.out_valid, done}, 3'b000);
      @(negedge clock);
      check({name, " start_after_done"}, {tx_if.out_valid, tx_if.out_data}, {1'b1, 8'h24});
      start = 1'b0;
      restart = 1'b1;
      @(negedge clock);
      restart = 1'b0;
    end else begin
      for (int k = 0; k < 4; k++) begin
        check({name, " idle_after"}, {busy, tx_if.out_valid, done}, 3'b000);
        @(negedge clock);
      end
    end
  endtask

  initial begin
    vec_t tbl[2];
    bq_t  e;
    int   n, cyc;

    tbl[0].f = mkf(8'h12, 8'h34, 8'h56, 8'h78, 8'h09, 8'h10, 16'h2021);
    tbl[0].body = "GPZDA,123456.78,09,10,2021,00,00";
    tbl[0].cks = "67";
    tbl[1].f = mkf(8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h01, 16'h2000);
    tbl[1].body = "GPZDA,000000.00,01,01,2000,00,00";
    tbl[1].cks = "64";

    tx_if.out_ready = 1'b1;
    repeat (3) @(negedge clock);
    check("reset outputs", {tx_if.out_valid, tx_if.out_data, busy, done}, '0);
    reset_n = 1'b1;
    @(negedge clock);
    check("idle after reset", {tx_if.out_valid, busy, done}, 3'b000);

    // Fixed sentences, full rate then backpressured.
    for (int v = 0; v < 2; v++) begin
      run_one($sformatf("vec%0d full", v), tbl[v].f, vec_expect(tbl[v]), 0, 1'b0);
      run_one($sformatf("vec%0d bp", v), tbl[v].f, vec_expect(tbl[v]), 1, 1'b0);
    end

    // Field changes and start pulses during the sentence are ignored.
    run_one("busy_start", tbl[0].f, vec_expect(tbl[0]), 2, 1'b0);

    // A start held through the done cycle is taken one cycle later.
    run_one("done_start", tbl[1].f, vec_expect(tbl[1]), 0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      check("after done_start restart", {busy, tx_if.out_valid, done}, 3'b000);
      @(negedge clock);
    end

    // Restart after ten transfers, coinciding with an eleventh.
    e = vec_expect(tbl[0]);
    set_fields(tbl[0].f);
    tx_if.out_ready = 1'b1;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    n = 0; cyc = 0;
    while (n < 10 && cyc < 100) begin
      if (tx_if.out_valid && tx_if.out_ready) n++;
      @(negedge clock);
      cyc++;
    end
    check("restart pre byte", {tx_if.out_valid, tx_if.out_data}, {1'b1, e[10]});
    restart = 1'b1;
    @(negedge clock);
    restart = 1'b0;
    check("restart drop", {tx_if.out_valid, busy, done}, 3'b000);
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      check("restart no done", {tx_if.out_valid, busy, done}, 3'b000);
    end
    run_one("after_restart", tbl[0].f, e, 0, 1'b0);

    // Asynchronous reset in the middle of a sentence.
    set_fields(tbl[1].f);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (5) @(negedge clock);
    check("pre reset valid", {tx_if.out_valid, busy}, 2'b11);
    #2 reset_n = 1'b0;
    #1 check("async reset outputs", {tx_if.out_valid, tx_if.out_data, busy, done}, '0);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    check("after reset idle", {tx_if.out_valid, busy, done}, 3'b000);
    run_one("after_reset", tbl[1].f, vec_expect(tbl[1]), 0, 1'b0);

    // Randomized fields (some with non-decimal nibbles) and ready.
    for (int r = 0; r < 8; r++) begin
      fields_t f;
      f = rnd_fields(r % 3 == 2);
      run_one($sformatf("rand%0d", r), f, model(f), (r % 2 == 0) ? 1 : 0, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
